// File: rtl/acc_core.sv
// rtl/acc_core.sv - accumulator core: fetch/execute FSM, ALU, flags and return-address stack.
module acc_core #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [AW-1:0]   imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [DW+3:0]   imem_data,
    output logic [AW-1:0]   pc,
    output logic [DW-1:0]   acc,
    output logic            zero_flag,
    output logic            carry_flag,
    output logic            halted,
    output logic            stack_err
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_JC   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t          state_q, state_d;
    logic [DW+3:0]   ir_q, ir_d;
    logic [AW-1:0]   pc_d;
    logic [DW-1:0]   acc_d;
    logic            z_d, c_d, err_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic            push_en;
    logic            upd_z;

    // Rounded up to a power of two so sp indexes the array at its natural width.
    logic [AW-1:0]   stack_mem [0:(2**SPW)-1];

    logic [3:0]      opcode;
    logic [DW-1:0]   operand;
    logic [AW-1:0]   target;
    logic [AW-1:0]   pc_inc;
    logic [DW:0]     sum;
    logic [DW:0]     diff;

    assign opcode  = ir_q[DW+3:DW];
    assign operand = ir_q[DW-1:0];
    assign target  = operand[AW-1:0];
    assign pc_inc  = pc + AW'(1);
    assign sum     = {1'b0, acc} + {1'b0, operand};
    assign diff    = {1'b0, acc} - {1'b0, operand};

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem_req  = (state_q == FETCH) && reset;
    assign imem_addr = pc;
    assign halted    = (state_q == HALT);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc;
        acc_d   = acc;
        z_d     = zero_flag;
        c_d     = carry_flag;
        sp_d    = sp_q;
        err_d   = stack_err;
        push_en = 1'b0;
        upd_z   = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_LOAD: begin acc_d = operand; upd_z = 1'b1; end
                    OP_ADD:  begin {c_d, acc_d} = sum; upd_z = 1'b1; end
                    OP_SUB:  begin {c_d, acc_d} = diff; upd_z = 1'b1; end
                    OP_JMP:  pc_d = target;
                    OP_JZ:   if (zero_flag) pc_d = target;
                    OP_JC:   if (carry_flag) pc_d = target;
                    OP_AND:  begin acc_d = acc & operand; upd_z = 1'b1; end
                    OP_OR:   begin acc_d = acc | operand; upd_z = 1'b1; end
                    OP_XOR:  begin acc_d = acc ^ operand; upd_z = 1'b1; end
                    OP_CALL: begin
                        if (sp_q == SP_FULL) begin
                            pc_d    = pc;
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SPW'(1);
                            pc_d    = target;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            pc_d    = pc;
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            sp_d = sp_q - SPW'(1);
                            pc_d = stack_mem[sp_q - SPW'(1)];
                        end
                    end
                    OP_HLT: begin
                        pc_d    = pc;
                        state_d = HALT;
                    end
                    default: ;
                endcase
                if (upd_z) z_d = (acc_d == '0);
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            pc         <= '0;
            acc        <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            sp_q       <= '0;
            stack_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc         <= pc_d;
            acc        <= acc_d;
            zero_flag  <= z_d;
            carry_flag <= c_d;
            sp_q       <= sp_d;
            stack_err  <= err_d;
        end
    end

    // push_en is only raised in EXEC, which reset clears asynchronously.
    always_ff @(posedge clk) begin
        if (push_en) stack_mem[sp_q] <= pc_inc;
    end

endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - scoreboard bench for acc_core (default instance plus AW=4/STACK_DEPTH=2 instance).
module tb_acc_core;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  addr0, pc0, acc0;
    logic        req0, z0, c0, h0, e0;
    logic        ack0 = 1'b0;
    logic [11:0] data0 = '0;

    logic [3:0]  addr1, pc1;
    logic [7:0]  acc1;
    logic        req1, z1, c1, h1, e1;
    logic        ack1 = 1'b0;
    logic [11:0] data1 = '0;

    acc_core u0 (
        .clk(clk), .reset(reset), .imem_addr(addr0), .imem_req(req0), .imem_ack(ack0),
        .imem_data(data0), .pc(pc0), .acc(acc0), .zero_flag(z0), .carry_flag(c0),
        .halted(h0), .stack_err(e0)
    );

    acc_core #(.DW(8), .AW(4), .STACK_DEPTH(2)) u1 (
        .clk(clk), .reset(reset), .imem_addr(addr1), .imem_req(req1), .imem_ack(ack1),
        .imem_data(data1), .pc(pc1), .acc(acc1), .zero_flag(z1), .carry_flag(c1),
        .halted(h1), .stack_err(e1)
    );

    logic [11:0] mem0 [0:255];
    logic [11:0] mem1 [0:15];
    int delay0 = 0, delay1 = 0, wait0 = 0, wait1 = 0;
    bit force_ack0 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [19:0] st;
        int          cycles;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (force_ack0) begin
            ack0 = 1'b1; data0 = mem0[addr0];
        end else if (req0) begin
            if (wait0 >= delay0) begin ack0 = 1'b1; data0 = mem0[addr0]; wait0 = 0; end
            else begin ack0 = 1'b0; wait0++; end
        end else begin
            ack0 = 1'b0; wait0 = 0;
        end
    end

    always @(negedge clk) begin
        if (req1) begin
            if (wait1 >= delay1) begin ack1 = 1'b1; data1 = mem1[addr1]; wait1 = 0; end
            else begin ack1 = 1'b0; wait1++; end
        end else begin
            ack1 = 1'b0; wait1 = 0;
        end
    end

    function automatic logic [19:0] obs0();
        return {pc0, acc0, z0, c0, h0, e0};
    endfunction

    function automatic logic [19:0] obs1();
        return {4'h0, pc1, acc1, z1, c1, h1, e1};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem0[i] = 12'hF00;
        for (int i = 0; i < 16; i++) mem1[i] = 12'hF00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_halt(input bit which, input int budget, output int cyc);
        cyc = 0;
        while (!(which ? h1 : h0) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_prog(input bit which, output int cyc);
        do_reset();
        wait_halt(which, 200, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs0() !== 20'h0 || req0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got st=%h req=%b expected st=00000 req=0", obs0(), req0);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (req0 !== 1'b1 || addr0 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h expected req=1 addr=00", req0, addr0);
        end
    endtask

    task automatic test_add_carry();
        exp_t e; int cyc;
        clear_mem();
        mem0[0] = 12'h105; mem0[1] = 12'h2FC; mem0[2] = 12'hF00;
        sb.push_back('{{8'h02, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0}, 6});
        run_prog(0, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL add_carry_state: got %h expected %h", obs0(), e.st); end
        n_cmp++;
        if (cyc !== e.cycles) begin n_bad++; $display("FAIL add_carry_cycles: got %0d expected %0d", cyc, e.cycles); end
    endtask

    task automatic test_sub_jz();
        exp_t e; int cyc;
        clear_mem();
        mem0[0] = 12'h103; mem0[1] = 12'h303; mem0[2] = 12'h510;
        sb.push_back('{{8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}, -1});
        run_prog(0, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL jz_taken: got %h expected %h", obs0(), e.st); end

        clear_mem();
        mem0[0] = 12'h103; mem0[1] = 12'h304; mem0[2] = 12'h510;
        sb.push_back('{{8'h03, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0}, -1});
        run_prog(0, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL jz_not_taken_borrow: got %h expected %h", obs0(), e.st); end
    endtask

    task automatic test_logic_jc();
        exp_t e; int cyc;
        clear_mem();
        mem0[0] = 12'h1FF; mem0[1] = 12'h201; mem0[2] = 12'h1F0; mem0[3] = 12'h73C;
        mem0[4] = 12'h80F; mem0[5] = 12'h93F; mem0[6] = 12'hC55; mem0[7] = 12'h630;
        sb.push_back('{{8'h30, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0}, -1});
        run_prog(0, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL logic_ops_jc: got %h expected %h", obs0(), e.st); end
    endtask

    task automatic test_call_ret();
        exp_t e; int cyc;
        clear_mem();
        mem0[0] = 12'hA20; mem0[8'h20] = 12'hB00; mem0[1] = 12'hF00;
        sb.push_back('{{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}, -1});
        run_prog(0, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL call_ret: got %h expected %h", obs0(), e.st); end

        clear_mem();
        mem0[0] = 12'hB00;
        sb.push_back('{{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}, 2});
        run_prog(0, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL ret_underflow: got %h expected %h", obs0(), e.st); end
        n_cmp++;
        if (cyc !== e.cycles) begin n_bad++; $display("FAIL ret_underflow_cycles: got %0d expected %0d", cyc, e.cycles); end
    endtask

    task automatic test_overflow();
        exp_t e; int cyc;
        clear_mem();
        mem1[0] = 12'hA04; mem1[4] = 12'hA08; mem1[8] = 12'hA0C;
        sb.push_back('{{8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}, -1});
        run_prog(1, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st) begin n_bad++; $display("FAIL call_overflow: got %h expected %h", obs1(), e.st); end
    endtask

    task automatic test_pc_wrap();
        exp_t e; int cyc;
        clear_mem();
        mem1[0] = 12'h503; mem1[1] = 12'h100; mem1[2] = 12'h40F; mem1[15] = 12'h000;
        sb.push_back('{{8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}, -1});
        run_prog(1, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st) begin n_bad++; $display("FAIL pc_wrap: got %h expected %h", obs1(), e.st); end
    endtask

    task automatic test_delayed_ack();
        exp_t e; int cyc;
        clear_mem();
        delay1 = 3;
        sb.push_back('{{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}, 5});
        do_reset();
        #1;
        n_cmp++;
        if (req1 !== 1'b1 || addr1 !== 4'h0) begin
            n_bad++; $display("FAIL delay_req_c0: got req=%b addr=%h expected req=1 addr=0", req1, addr1);
        end
        cyc = 0;
        while (!h1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc < 4) begin
                n_cmp++;
                if (req1 !== 1'b1 || addr1 !== 4'h0) begin
                    n_bad++; $display("FAIL delay_req_c%0d: got req=%b addr=%h expected req=1 addr=0", cyc, req1, addr1);
                end
            end
        end
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st) begin n_bad++; $display("FAIL delay_state: got %h expected %h", obs1(), e.st); end
        n_cmp++;
        if (cyc !== e.cycles) begin n_bad++; $display("FAIL delay_cycles: got %0d expected %0d", cyc, e.cycles); end
        delay1 = 0;
    endtask

    task automatic test_reset_mid_fetch();
        exp_t e; int cyc;
        clear_mem();
        mem0[0] = 12'h1AA; mem0[1] = 12'hF00;
        sb.push_back('{{8'h01, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0}, -1});
        do_reset();
        @(negedge clk); #2;
        force_ack0 = 1'b1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs0() !== 20'h0 || req0 !== 1'b0) begin
            n_bad++; $display("FAIL midfetch_async: got st=%h req=%b expected st=00000 req=0", obs0(), req0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs0() !== 20'h0 || ack0 !== 1'b1) begin
            n_bad++; $display("FAIL midfetch_ack_ignored: got st=%h ack=%b expected st=00000 ack=1", obs0(), ack0);
        end
        force_ack0 = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        wait_halt(0, 50, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (obs0() !== e.st) begin n_bad++; $display("FAIL midfetch_rerun: got %h expected %h", obs0(), e.st); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_add_carry();
        test_sub_jz();
        test_logic_jc();
        test_call_ret();
        test_overflow();
        test_pc_wrap();
        test_delayed_ack();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_core.md
ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 SHALL have parameter DW, default 8, accumulator/operand data width (4..32).
REQ-002 SHALL have parameter AW, default 8, program address width (2..DW).
REQ-003 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 SHALL have port imem_addr  output  AW  fetch address (equals pc).
REQ-007 SHALL have port imem_req  output  1  fetch request.
REQ-008 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-009 SHALL have port imem_data  input  4+DW  instruction {opcode[DW+3:DW], operand[DW-1:0]}.
REQ-010 SHALL have port pc  output  AW  current program counter.
REQ-011 SHALL have port acc  output  DW  accumulator.
REQ-012 SHALL have port zero_flag  output  1  Z flag.
REQ-013 SHALL have port carry_flag  output  1  C flag.
REQ-014 SHALL have port halted  output  1  core stopped.
REQ-015 SHALL have port stack_err  output  1  halt caused by stack over/underflow.

Function
REQ-016 SHALL implement FSM states FETCH, EXEC, HALT; FETCH->EXEC on imem_ack, EXEC->FETCH otherwise EXEC->HALT on HLT or stack error; HALT is terminal until reset.
REQ-017 SHALL drive imem_req=1 only in FETCH with reset deasserted; imem_addr SHALL stay equal to pc while imem_req=1.
REQ-018 SHALL latch imem_data on the edge where imem_req=1 and imem_ack=1; imem_ack outside FETCH SHALL be ignored.
REQ-019 SHALL take minimum 2 cycles per instruction (ack in first FETCH cycle); each wait cycle without ack adds 1.
REQ-020 SHALL, in EXEC for non-branch opcodes, set pc = pc+1 modulo 2^AW (pc=2^AW-1 wraps to 0).
REQ-021 SHALL decode: 0 NOP; 1 LOAD acc=operand; 2 ADD; 3 SUB; 4 JMP; 5 JZ; 6 JC; 7 AND; 8 OR; 9 XOR; A CALL; B RET; F HLT; C/D/E execute as NOP.
REQ-022 SHALL compute ADD as {C,acc}=acc+operand in DW+1 bits; SUB as acc-operand modulo 2^DW with C=1 on borrow (operand>acc).
REQ-023 SHALL update Z=(new acc==0) on LOAD/ADD/SUB/AND/OR/XOR; C only on ADD/SUB; AND/OR/XOR/LOAD leave C unchanged.
REQ-024 SHALL use operand[AW-1:0] as target for JMP/JZ/JC/CALL; JZ/JC use flag values before the EXEC edge; not-taken branch increments pc.
REQ-025 SHALL on CALL push pc+1 (mod 2^AW) and jump; on RET pop into pc.
REQ-026 SHALL on CALL with STACK_DEPTH entries occupied, or RET with stack empty, leave pc/stack unchanged, set stack_err=1, enter HALT.
REQ-027 SHALL on HLT keep pc at HLT address, set halted=1, keep acc/flags frozen.
REQ-028 SHALL hold halted=1 in HALT state and 0 elsewhere.

Reset
REQ-029 SHALL, while reset=0, asynchronously force pc=0, acc=0, Z=0, C=0, stack pointer=0, stack_err=0, halted=0, state=FETCH, imem_req=0.
REQ-030 SHALL assert imem_req=1 with imem_addr=0 in the first cycle after reset deasserts.
REQ-031 SHALL abort any fetch or execution in progress when reset asserts; a pending imem_ack during reset SHALL be discarded.

Verification
REQ-032 LOAD 0x05, ADD 0xFC, HLT, ack every cycle (DW=8) -> acc=0x01, C=1, Z=0, halted=1 after 6 cycles, pc=2.
REQ-033 LOAD 0x03, SUB 0x03, JZ 0x10 -> acc=0, Z=1, C=0, pc=0x10; repeat with SUB 0x04 -> acc=0xFF, C=1, Z=0, pc=3.
REQ-034 CALL 0x20; at 0x20 RET -> pc=0x01 after RET; RET with empty stack at reset -> stack_err=1, halted=1, pc=0.
REQ-035 STACK_DEPTH=2, three nested CALLs -> third CALL sets stack_err=1, halted=1, pc=third CALL address.
REQ-036 AW=4, NOP at 0xF -> pc wraps to 0x0; imem_ack delayed 3 cycles -> imem_req/imem_addr stable, instruction takes 5 cycles.
REQ-037 reset asserted mid-FETCH with imem_ack=1 -> all outputs at reset values same cycle, acc unchanged by that ack.
